seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Display-side consumer of the per-digit value codes produced by the game's digit-handling logic. It captures four 4-bit digit codes into shadow registers on a load strobe and time-multiplexes them onto a 4-digit common-anode seven-segment display. Each digit can blink independently, and leading zeros can be suppressed. It sits between the digit-handling blocks and the board's an/seg pins.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit stays selected; legal range ≥ 2.
- BLINK_DIV, default 25000000: clock cycles per blink half-period; legal range ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- val0..val3  in  4 each  digit codes. val0 is the rightmost digit and val3 the leftmost. Codes 0–9 are numerals, 10 is dash, and 11–15 are blank (13 is the blank code used by the digit-handling blocks).
- load  in  1  capture val0..val3 into the shadow registers on this edge.
- blink_en  in  4  bit i high: digit i blanks during the off phase of the blink.
- lz_blank  in  1  suppress leading zeros on digits 3..1.
- an  out  4  anode enables, active-low, one-hot-low while running.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held at 1 (off).
- frame_done  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Reset values:
  - shadow registers = 13.
  - tick counter = 0, idx = 0, blink counter = 0, blink phase = 0 (on).
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_done = 0.
- Shadow registers:
  - On a load edge, all four registers take val0..val3.
  - If load is low, they hold.
  - val* are never read directly for display.
- Scan:
  - The tick counter counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, idx advances 0→1→2→3→0.
  - When idx goes 3→0, frame_done is 1 for exactly one cycle.
- Blink:
  - The blink counter counts 0..BLINK_DIV-1.
  - On wrap, the blink phase toggles.
  - Digit i is forced blank when phase = 1 (off) and blink_en[i] = 1.
- Leading-zero suppression (lz_blank = 1), evaluated on the shadow values:
  - Digit 3 is blank if its code is 0.
  - Digit 2 is blank if its code is 0 and digit 3 is suppressed.
  - Digit 1 is blank if its code is 0 and digit 2 is suppressed.
  - Digit 0 is never suppressed.
- Decode, as seg patterns:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - 10 = 0111111.
  - 11–15 and any blank condition = 1111111.
- an drives low only the bit for the current idx. A blanked digit still has its anode enabled, with seg all 1.

## Timing
- an, seg and frame_done are registered.
  - The output in cycle t reflects idx, shadow, blink phase and lz_blank as they stood at the end of cycle t-1.
  - Consequence: the first active output appears 1 cycle after reset release, showing digit 0 as blank (code 13).
- Load-to-display latency:
  - The shadow updates on the load edge.
  - The new code appears on seg one cycle later, provided its digit is currently selected.
  - Otherwise it appears when that digit is next scanned, within at most 4·REFRESH_DIV + 1 cycles.
- load coinciding with a scan advance: the newly selected digit shows the newly loaded value one cycle later. No stale or mixed frame is emitted for that digit.
- frame_done coinciding with load: both take effect. The new frame starts with the new values.
- blink_en and lz_blank changes take effect on the next output update. No resynchronisation is required.
- Reset asserted mid-scan: all outputs go to their reset values immediately (asynchronously). Scanning restarts from idx 0 after release.
- Tick and blink counters are free-running and are unaffected by load.

## Test plan
- Reset then release, with REFRESH_DIV = 4 and no load:
  - Cycle 1: an = 1110, seg = 1111111.
  - After 4 cycles: an = 1101.
  - After 16 cycles: frame_done pulses once, an = 1110.
- Pulse load with val3..val0 = 3,0,5,9:
  - While an = 1110, seg = 0010000.
  - an = 1101 → 0010010.
  - an = 1011 → 1000000.
  - an = 0111 → 0110000.
- lz_blank = 1 with codes 0,0,7,0 (val3..val0):
  - Digits 3 and 2 show 1111111.
  - Digit 1 shows 1111000.
  - Digit 0 shows 1000000.
- BLINK_DIV = 8, blink_en = 0001, codes all 8:
  - Digit 0 alternates between 0000000 and 1111111 every 8 cycles.
  - Digits 1–3 stay 0000000.
- Load codes 10 and 13 into val3 and val2:
  - Digit 3 shows 0111111.
  - Digit 2 shows 1111111.
- Assert rst_n low mid-frame while an = 1011:
  - an = 1111 and seg = 1111111 without waiting for a clock edge.
  - Shadow registers return to 13.
  - After release, the scan restarts at an = 1110.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: captures four 4-bit digit codes into shadow registers on a
// load strobe and time-multiplexes them onto a 4-digit common-anode
// seven-segment display, with per-digit blink and leading-zero suppression.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] val0,
    input  logic [3:0] val1,
    input  logic [3:0] val2,
    input  logic [3:0] val3,
    input  logic       load,
    input  logic [3:0] blink_en,
    input  logic       lz_blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int TW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [3:0] CODE_BLANK = 4'd13;
    localparam logic [6:0] SEG_OFF    = 7'b1111111;

    logic [3:0]    shadow [4];
    logic [TW-1:0] tick;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic          tick_wrap;
    logic          blink_wrap;
    logic [3:0]    cur_code;
    logic          digit_blank;
    logic [6:0]    next_seg;

    // Segment patterns {g,f,e,d,c,b,a}, active-low; codes 11..15 are blank.
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'd10:   return 7'b0111111;
            default: return SEG_OFF;
        endcase
    endfunction

    assign tick_wrap  = (tick == TICK_LAST);
    assign blink_wrap = (blink_cnt == BLINK_LAST);
    assign cur_code   = shadow[idx];
    assign dp         = 1'b1;

    // Work out whether the currently selected digit is blanked and its pattern.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        logic sup3, sup2, sup1;
        digit_blank = 1'b0;
        next_seg    = SEG_OFF;
        // Suppression ripples down from the leftmost digit; digit 0 always shows.
        sup3 = lz_blank && (shadow[3] == 4'd0);
        sup2 = sup3 && (shadow[2] == 4'd0);
        sup1 = sup2 && (shadow[1] == 4'd0);
        if (blink_phase && blink_en[idx]) digit_blank = 1'b1;
        case (idx)
            2'd3:    if (sup3) digit_blank = 1'b1;
            2'd2:    if (sup2) digit_blank = 1'b1;
            2'd1:    if (sup1) digit_blank = 1'b1;
            default: ;
        endcase
        next_seg = digit_blank ? SEG_OFF : decode(cur_code);
    end

    // Capture the incoming digit codes; the display reads only these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            // NOTE: only four registers, and their blank reset value is
            // visible on the display, so this small array is reset.
            for (int i = 0; i < 4; i++) shadow[i] <= CODE_BLANK;
        end else if (load) begin
            shadow[0] <= val0;
            shadow[1] <= val1;
            shadow[2] <= val2;
            shadow[3] <= val3;
        end
    end

    // Free-running refresh tick and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            idx  <= 2'd0;
        end else if (tick_wrap) begin
            tick <= '0;
            idx  <= idx + 2'd1;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    // Free-running blink half-period counter and phase (0 = on, 1 = off).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Registered display outputs, computed from the state held before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= ~(4'b0001 << idx);
            seg        <= next_seg;
            frame_done <= tick_wrap && (idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed bench for seven_seg_scan with REFRESH_DIV = 4
// and BLINK_DIV = 8. n counts rising edges since the last reset release;
// the output sampled after edge n reflects the state after n-1 edges, so the
// displayed digit is ((n-1)/4)%4 and the blink phase is ((n-1)/8)%2.
module tb_seven_seg_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] val0, val1, val2, val3;
    logic       load;
    logic [3:0] blink_en;
    logic       lz_blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    seven_seg_scan #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .val0      (val0),
        .val1      (val1),
        .val2      (val2),
        .val3      (val3),
        .load      (load),
        .blink_en  (blink_en),
        .lz_blank  (lz_blank),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
        n += k;
    endtask

    task automatic adv_to(input int target);
        if (target > n) step(target - n);
    endtask

    // Present codes with load high so they are captured on the next edge.
    task automatic load_vals(input logic [3:0] v3, input logic [3:0] v2,
                             input logic [3:0] v1, input logic [3:0] v0);
        val3 = v3; val2 = v2; val1 = v1; val0 = v0;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        val0     = 4'd0; val1 = 4'd0; val2 = 4'd0; val3 = 4'd0;
        load     = 1'b0;
        blink_en = 4'b0000;
        lz_blank = 1'b0;

        // Reset state
        #12;
        check("rst_an",  32'(an),         32'b1111);
        check("rst_seg", 32'(seg),        32'b1111111);
        check("rst_dp",  32'(dp),         32'd1);
        check("rst_fd",  32'(frame_done), 32'd0);

        // Scan without load: blank digits, frame wrap after 16 cycles
        release_reset();
        adv_to(1);
        check("a_n1_an",  32'(an),  32'b1110);
        check("a_n1_seg", 32'(seg), 32'b1111111);
        check("a_n1_dp",  32'(dp),  32'd1);
        adv_to(4);
        check("a_n4_an",  32'(an),  32'b1110);
        adv_to(5);
        check("a_n5_an",  32'(an),  32'b1101);
        adv_to(15);
        check("a_n15_fd", 32'(frame_done), 32'd0);
        adv_to(16);
        check("a_n16_fd", 32'(frame_done), 32'd1);
        check("a_n16_an", 32'(an), 32'b0111);
        adv_to(17);
        check("a_n17_fd", 32'(frame_done), 32'd0);
        check("a_n17_an", 32'(an), 32'b1110);

        // Load 3,0,5,9 (captured at edge 18)
        load_vals(4'd3, 4'd0, 4'd5, 4'd9);
        adv_to(19);
        check("b_d0_an",  32'(an),  32'b1110);
        check("b_d0_seg", 32'(seg), 32'b0010000);
        adv_to(21);
        check("b_d1_an",  32'(an),  32'b1101);
        check("b_d1_seg", 32'(seg), 32'b0010010);
        adv_to(25);
        check("b_d2_an",  32'(an),  32'b1011);
        check("b_d2_seg", 32'(seg), 32'b1000000);
        adv_to(29);
        check("b_d3_an",  32'(an),  32'b0111);
        check("b_d3_seg", 32'(seg), 32'b0110000);

        // Leading-zero suppression, 0,0,7,0; the load edge 32 also advances to digit 0
        adv_to(31);
        lz_blank = 1'b1;
        load_vals(4'd0, 4'd0, 4'd7, 4'd0);
        adv_to(33);
        check("c_d0_an",  32'(an),  32'b1110);
        check("c_d0_seg", 32'(seg), 32'b1000000);
        adv_to(37);
        check("c_d1_seg", 32'(seg), 32'b1111000);
        adv_to(41);
        check("c_d2_seg", 32'(seg), 32'b1111111);
        adv_to(45);
        check("c_d3_an",  32'(an),  32'b0111);
        check("c_d3_seg", 32'(seg), 32'b1111111);

        // Blink with all digits at 8
        lz_blank = 1'b0;
        blink_en = 4'b0001;
        load_vals(4'd8, 4'd8, 4'd8, 4'd8);
        adv_to(49);
        check("d_d0_on",    32'(seg), 32'b0000000);
        adv_to(57);
        check("d_d2_off_notsel", 32'(seg), 32'b0000000);
        blink_en = 4'b0100;
        adv_to(58);
        check("d_d2_off_sel", 32'(seg), 32'b1111111);
        check("d_d2_an",      32'(an),  32'b1011);
        adv_to(61);
        check("d_d3_off_notsel", 32'(seg), 32'b0000000);
        adv_to(65);
        check("d_d0_notsel", 32'(seg), 32'b0000000);
        adv_to(73);
        check("d_d2_off_again", 32'(seg), 32'b1111111);
        blink_en = 4'b0000;
        adv_to(74);
        check("d_blink_cleared", 32'(seg), 32'b0000000);

        // Dash and blank code 13, plus frame_done during a loaded frame
        load_vals(4'd10, 4'd13, 4'd1, 4'd2);
        adv_to(77);
        check("e_d3_an",   32'(an),  32'b0111);
        check("e_d3_dash", 32'(seg), 32'b0111111);
        adv_to(80);
        check("e_fd",      32'(frame_done), 32'd1);
        adv_to(81);
        check("e_fd_low",  32'(frame_done), 32'd0);
        check("e_d0_seg",  32'(seg), 32'b0100100);
        adv_to(85);
        check("e_d1_seg",  32'(seg), 32'b1111001);
        adv_to(89);
        check("e_d2_an",   32'(an),  32'b1011);
        check("e_d2_b13",  32'(seg), 32'b1111111);

        // Suppression chain broken by a nonzero digit 2: 0,5,0,0
        lz_blank = 1'b1;
        load_vals(4'd0, 4'd5, 4'd0, 4'd0);
        adv_to(93);
        check("f_d3_seg", 32'(seg), 32'b1111111);
        adv_to(97);
        check("f_d0_seg", 32'(seg), 32'b1000000);
        adv_to(101);
        check("f_d1_seg", 32'(seg), 32'b1000000);
        adv_to(105);
        check("f_d2_an",  32'(an),  32'b1011);
        check("f_d2_seg", 32'(seg), 32'b0010010);

        // Asynchronous reset mid-frame while an = 1011
        lz_blank = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("g_async_an",  32'(an),         32'b1111);
        check("g_async_seg", 32'(seg),        32'b1111111);
        check("g_async_fd",  32'(frame_done), 32'd0);
        @(negedge clk);
        release_reset();
        adv_to(1);
        check("g_n1_an",  32'(an),  32'b1110);
        check("g_n1_seg", 32'(seg), 32'b1111111);
        adv_to(5);
        check("g_d1_seg", 32'(seg), 32'b1111111);
        adv_to(9);
        check("g_d2_an",  32'(an),  32'b1011);
        check("g_d2_seg", 32'(seg), 32'b1111111);
        adv_to(13);
        check("g_d3_seg", 32'(seg), 32'b1111111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
